// File: rtl/preta_tile_gen_if.sv
// Pixel-stream input and tile output bundle of the Winograd pre-transform tile generator.
interface preta_tile_gen_if #(
    parameter int unsigned DATA_W = 16
);
    logic                   pix_valid;
    logic                   pix_sof;
    logic [DATA_W-1:0]      pix_data;
    logic                   tile_valid;
    logic [DATA_W*16-1:0]   tile_flat;
    logic [7:0]             tile_row;
    logic [7:0]             tile_col;
    logic                   frame_done;
    logic                   pix_drop;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  tile_valid, tile_flat, tile_row, tile_col, frame_done, pix_drop
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output tile_valid, tile_flat, tile_row, tile_col, frame_done, pix_drop
    );
endinterface

// File: rtl/preta_tile_gen.sv
// Raster pixel stream -> overlapping 4x4 tiles (stride 2, no padding) for the Winograd pre-transform.
// Optional PRETA_TILE_CNT_EN adds a free-running 16-bit tile_count output.
module preta_tile_gen #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    preta_tile_gen_if.slave   tif
`ifdef PRETA_TILE_CNT_EN
    ,
    output logic [15:0]       tile_count
`endif
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned FW = DATA_W * 16;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DATA_W-1:0] win_q [4][4];
    logic [DATA_W-1:0] win_d [4][4];
    logic [DATA_W-1:0] lb_q  [3][IMG_W];
    logic              tile_valid_q, tile_valid_d;
    logic [FW-1:0]     tile_flat_q, tile_flat_d;
    logic [7:0]        tile_row_q, tile_row_d;
    logic [7:0]        tile_col_q, tile_col_d;
    logic              frame_done_q, frame_done_d;
    logic              pix_drop_q, pix_drop_d;
    logic              acc_c;
    logic [RW-1:0]     y_c;
    logic [CW-1:0]     x_c;

    // Next-state: pixel acceptance, raster position, window shift and tile emission.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        tile_valid_d = 1'b0;
        tile_flat_d  = tile_flat_q;
        tile_row_d   = tile_row_q;
        tile_col_d   = tile_col_q;
        frame_done_d = 1'b0;
        pix_drop_d   = 1'b0;
        acc_c        = 1'b0;
        y_c          = row_q;
        x_c          = col_q;

        if (tif.pix_valid) begin
            if (tif.pix_sof) begin
                acc_c = 1'b1;
                y_c   = '0;
                x_c   = '0;
            end else if (state_q == ACTIVE) begin
                acc_c = 1'b1;
            end else begin
                pix_drop_d = 1'b1;
            end
        end

        if (acc_c) begin
            state_d = ACTIVE;
            if (x_c == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (y_c == RW'(IMG_H - 1)) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = y_c + 1'b1;
                end
            end else begin
                col_d = x_c + 1'b1;
                row_d = y_c;
            end

            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][3] = lb_q[0][x_c];
            win_d[1][3] = lb_q[1][x_c];
            win_d[2][3] = lb_q[2][x_c];
            win_d[3][3] = tif.pix_data;

            // Odd y/x at or past 3 is exactly the stride-2 anchor of a full 4x4 window.
            if (y_c >= RW'(3) && x_c >= CW'(3) && y_c[0] && x_c[0]) begin
                tile_valid_d = 1'b1;
                tile_row_d   = 8'((y_c - RW'(3)) >> 1);
                tile_col_d   = 8'((x_c - CW'(3)) >> 1);
                frame_done_d = (y_c == RW'(IMG_H - 1)) && (x_c == CW'(IMG_W - 1));
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        tile_flat_d[(r*4+c)*DATA_W +: DATA_W] = win_d[r][c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            tile_valid_q <= 1'b0;
            tile_flat_q  <= '0;
            tile_row_q   <= '0;
            tile_col_q   <= '0;
            frame_done_q <= 1'b0;
            pix_drop_q   <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            tile_valid_q <= tile_valid_d;
            tile_flat_q  <= tile_flat_d;
            tile_row_q   <= tile_row_d;
            tile_col_q   <= tile_col_d;
            frame_done_q <= frame_done_d;
            pix_drop_q   <= pix_drop_d;
            win_q        <= win_d;
        end
    end

    // Line buffers shift per column: [0]=row y-3, [1]=y-2, [2]=y-1.
    always_ff @(posedge clk) begin
        if (acc_c) begin
            lb_q[0][x_c] <= lb_q[1][x_c];
            lb_q[1][x_c] <= lb_q[2][x_c];
            lb_q[2][x_c] <= tif.pix_data;
        end
    end

    assign tif.tile_valid = tile_valid_q;
    assign tif.tile_flat  = tile_flat_q;
    assign tif.tile_row   = tile_row_q;
    assign tif.tile_col   = tile_col_q;
    assign tif.frame_done = frame_done_q;
    assign tif.pix_drop   = pix_drop_q;

`ifdef PRETA_TILE_CNT_EN
    logic [15:0] tile_cnt_q, tile_cnt_d;

    always_comb begin
        tile_cnt_d = tile_cnt_q + 16'(tile_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt_q <= '0;
        end else begin
            tile_cnt_q <= tile_cnt_d;
        end
    end

    assign tile_count = tile_cnt_q;
`endif
endmodule

// File: tb/tb_preta_tile_gen.sv
// Directed bench for preta_tile_gen on an 8x8 frame with pixel value base + y*8 + x.
module tb_preta_tile_gen;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 8;
    localparam int unsigned FW = DW * 16;

    typedef struct packed {
        logic [FW-1:0] flat;
        logic [7:0]    row;
        logic [7:0]    col;
        logic          done;
    } tile_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   drops = 0;
    tile_t tq[$];

    always #5 clk = ~clk;

    preta_tile_gen_if #(.DATA_W(DW)) bus ();

`ifdef PRETA_TILE_CNT_EN
    logic [15:0] tile_count;
    preta_tile_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .tif(bus), .tile_count(tile_count));
`else
    preta_tile_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .tif(bus));
`endif

    // Collect emitted tiles and drop pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.tile_valid) tq.push_back({bus.tile_flat, bus.tile_row, bus.tile_col, bus.frame_done});
        if (bus.pix_drop) drops++;
    end

    function automatic logic [FW-1:0] exp_tile(input int base, input int r, input int c);
        logic [FW-1:0] e;
        e = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                e[(i*4+j)*DW +: DW] = DW'(base + (2*r+i)*int'(W) + 2*c + j);
        return e;
    endfunction

    task automatic drive(input logic v, input logic s, input int d);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_data  = DW'(d);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    task automatic send_pixels(input int base, input int first, input int last, input bit rnd);
        for (int p = first; p <= last; p++) begin
            if (rnd) while ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 0);
            drive(1'b1, p == 0, base + p);
        end
    endtask

    task automatic test_reset();
        bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.tile_valid !== 1'b0) begin failures++; $display("FAIL reset_tile_valid got %b exp 0", bus.tile_valid); end
        checks++; if (bus.tile_flat !== '0) begin failures++; $display("FAIL reset_tile_flat got %h exp 0", bus.tile_flat); end
        checks++; if (bus.tile_row !== 8'd0 || bus.tile_col !== 8'd0) begin failures++; $display("FAIL reset_row_col got %0d/%0d exp 0/0", bus.tile_row, bus.tile_col); end
        checks++; if (bus.frame_done !== 1'b0 || bus.pix_drop !== 1'b0) begin failures++; $display("FAIL reset_done_drop got %b/%b exp 0/0", bus.frame_done, bus.pix_drop); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_full_frame();
        logic [FW-1:0] f;
        tq.delete();
        send_pixels(0, 0, 26, 1'b0);
        checks++; if (bus.tile_valid !== 1'b0) begin failures++; $display("FAIL early_tile got %b exp 0", bus.tile_valid); end
        drive(1'b1, 1'b0, 27);
        f = bus.tile_flat;
        checks++; if (bus.tile_valid !== 1'b1) begin failures++; $display("FAIL first_tile_latency got %b exp 1", bus.tile_valid); end
        checks++; if (f[0*DW +: DW] !== 16'd0 || f[3*DW +: DW] !== 16'd3 || f[12*DW +: DW] !== 16'd24 || f[15*DW +: DW] !== 16'd27)
            begin failures++; $display("FAIL first_tile_corners got %0d %0d %0d %0d exp 0 3 24 27", f[0 +: DW], f[3*DW +: DW], f[12*DW +: DW], f[15*DW +: DW]); end
        checks++; if (bus.tile_row !== 8'd0 || bus.tile_col !== 8'd0) begin failures++; $display("FAIL first_tile_rc got %0d/%0d exp 0/0", bus.tile_row, bus.tile_col); end
        send_pixels(0, 28, 63, 1'b0);
        idle(3);
        checks++; if (tq.size() != 9) begin failures++; $display("FAIL full_count got %0d exp 9", tq.size()); end
        if (tq.size() == 9) begin
            f = tq[1].flat;
            checks++; if (f[DW-1:0] !== 16'd2) begin failures++; $display("FAIL tile2_e00 got %0d exp 2", f[DW-1:0]); end
            f = tq[3].flat;
            checks++; if (f[DW-1:0] !== 16'd16) begin failures++; $display("FAIL tile4_e00 got %0d exp 16", f[DW-1:0]); end
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (tq[k].flat !== exp_tile(0, k/3, k%3) || tq[k].row !== 8'(k/3) || tq[k].col !== 8'(k%3) || tq[k].done !== (k == 8)) begin
                    failures++;
                    $display("FAIL full_tile%0d got flat=%h rc=%0d/%0d done=%b exp flat=%h rc=%0d/%0d", k, tq[k].flat, tq[k].row, tq[k].col, tq[k].done, exp_tile(0, k/3, k%3), k/3, k%3);
                end
            end
        end
    endtask

    task automatic test_random_duty();
        logic [FW-1:0] f;
        tq.delete();
        send_pixels(0, 0, 63, 1'b1);
        idle(3);
        checks++; if (tq.size() != 9) begin failures++; $display("FAIL duty_count got %0d exp 9", tq.size()); end
        if (tq.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (tq[k].flat !== exp_tile(0, k/3, k%3) || tq[k].row !== 8'(k/3) || tq[k].col !== 8'(k%3) || tq[k].done !== (k == 8)) begin
                    failures++;
                    $display("FAIL duty_tile%0d got flat=%h rc=%0d/%0d done=%b exp flat=%h", k, tq[k].flat, tq[k].row, tq[k].col, tq[k].done, exp_tile(0, k/3, k%3));
                end
            end
            f = tq[8].flat;
            checks++; if (f[15*DW +: DW] !== 16'd63 || tq[8].row !== 8'd2 || tq[8].col !== 8'd2 || tq[8].done !== 1'b1)
                begin failures++; $display("FAIL duty_last got e33=%0d rc=%0d/%0d done=%b exp 63 2/2 1", f[15*DW +: DW], tq[8].row, tq[8].col, tq[8].done); end
        end
    endtask

    task automatic test_drop();
        tq.delete();
        drops = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 7 + i);
        idle(2);
        checks++; if (drops != 5) begin failures++; $display("FAIL drop_count got %0d exp 5", drops); end
        checks++; if (tq.size() != 0) begin failures++; $display("FAIL drop_no_tiles got %0d exp 0", tq.size()); end
        send_pixels(500, 0, 63, 1'b0);
        idle(3);
        checks++; if (tq.size() != 9) begin failures++; $display("FAIL drop_frame_count got %0d exp 9", tq.size()); end
        if (tq.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (tq[k].flat !== exp_tile(500, k/3, k%3) || tq[k].row !== 8'(k/3) || tq[k].col !== 8'(k%3) || tq[k].done !== (k == 8)) begin
                    failures++;
                    $display("FAIL drop_tile%0d got flat=%h exp flat=%h", k, tq[k].flat, exp_tile(500, k/3, k%3));
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        int dones;
        tq.delete();
        send_pixels(1000, 0, 39, 1'b0);
        send_pixels(0, 0, 63, 1'b0);
        idle(3);
        dones = 0;
        foreach (tq[k]) if (tq[k].done) dones++;
        checks++; if (tq.size() != 12) begin failures++; $display("FAIL midsof_count got %0d exp 12", tq.size()); end
        checks++; if (dones != 1) begin failures++; $display("FAIL midsof_done_count got %0d exp 1", dones); end
        if (tq.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                int b, t;
                b = (k < 3) ? 1000 : 0;
                t = (k < 3) ? k : k - 3;
                checks++;
                if (tq[k].flat !== exp_tile(b, t/3, t%3) || tq[k].row !== 8'(t/3) || tq[k].col !== 8'(t%3) || tq[k].done !== (k == 11)) begin
                    failures++;
                    $display("FAIL midsof_tile%0d got flat=%h rc=%0d/%0d done=%b exp flat=%h rc=%0d/%0d", k, tq[k].flat, tq[k].row, tq[k].col, tq[k].done, exp_tile(b, t/3, t%3), t/3, t%3);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        tq.delete();
        send_pixels(0, 0, 29, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.tile_valid !== 1'b0 || bus.tile_flat !== '0) begin failures++; $display("FAIL areset_tile got v=%b flat=%h exp 0", bus.tile_valid, bus.tile_flat); end
        checks++; if (bus.tile_col !== 8'd0 || bus.tile_row !== 8'd0) begin failures++; $display("FAIL areset_rc got %0d/%0d exp 0/0", bus.tile_row, bus.tile_col); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(2);
        drops = 0;
        drive(1'b1, 1'b0, 31);
        idle(2);
        checks++; if (drops != 1) begin failures++; $display("FAIL areset_needs_sof got drops=%0d exp 1", drops); end
        tq.delete();
        send_pixels(2000, 0, 63, 1'b0);
        idle(3);
        checks++; if (tq.size() != 9) begin failures++; $display("FAIL areset_count got %0d exp 9", tq.size()); end
        if (tq.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (tq[k].flat !== exp_tile(2000, k/3, k%3) || tq[k].row !== 8'(k/3) || tq[k].col !== 8'(k%3) || tq[k].done !== (k == 8)) begin
                    failures++;
                    $display("FAIL areset_tile%0d got flat=%h exp flat=%h", k, tq[k].flat, exp_tile(2000, k/3, k%3));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        rst_n = 1'b0;
        #7 rst_n = 1'b1;
        idle(2);
        tq.delete();
        send_pixels(0, 0, 63, 1'b0);
        send_pixels(3000, 0, 63, 1'b0);
        idle(3);
        dones = 0;
        foreach (tq[k]) if (tq[k].done) dones++;
        checks++; if (tq.size() != 18) begin failures++; $display("FAIL b2b_count got %0d exp 18", tq.size()); end
        checks++; if (dones != 2) begin failures++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
        if (tq.size() == 18) begin
            for (int k = 0; k < 18; k++) begin
                int b, t;
                b = (k < 9) ? 0 : 3000;
                t = k % 9;
                checks++;
                if (tq[k].flat !== exp_tile(b, t/3, t%3) || tq[k].row !== 8'(t/3) || tq[k].col !== 8'(t%3) || tq[k].done !== (t == 8)) begin
                    failures++;
                    $display("FAIL b2b_tile%0d got flat=%h exp flat=%h", k, tq[k].flat, exp_tile(b, t/3, t%3));
                end
            end
        end
`ifdef PRETA_TILE_CNT_EN
        checks++; if (tile_count !== 16'd18) begin failures++; $display("FAIL tile_count got %0d exp 18", tile_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_duty();
        test_drop();
        test_mid_sof();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
